// File: rtl/matrix_bram_server.sv
// Dual-port byte memory: port A answers the flip controller's BRAM accesses,
// port B is driven by a host engine that loads and dumps byte streams.
module matrix_bram_server #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_din,
   input  logic                  bram_we,
   output logic [DATA_WIDTH-1:0] bram_dout,
   input  logic                  host_cmd_valid,
   output logic                  host_cmd_ready,
   input  logic                  host_cmd_op,
   input  logic [ADDR_WIDTH-1:0] host_cmd_addr,
   input  logic [7:0]            host_cmd_len,
   input  logic                  host_in_valid,
   output logic                  host_in_ready,
   input  logic [DATA_WIDTH-1:0] host_in_data,
   output logic                  host_out_valid,
   input  logic                  host_out_ready,
   output logic [DATA_WIDTH-1:0] host_out_data,
   output logic                  host_done,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DUMP_REQ,
      S_DUMP_HOLD,
      S_DONE
   } state_t;

   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  b_we;

   assign b_we = (state_q == S_LOAD) && host_in_valid;

   // Port A is written last so it wins a same-address collision with port B.
   always_ff @(posedge clk) begin
      if (b_we) mem[ptr_q] <= host_in_data;
      if (bram_we) mem[bram_addr] <= bram_din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
         rd_q   <= '0;
      end else begin
         dout_q <= mem[bram_addr];
         if (state_q == S_DUMP_REQ) rd_q <= mem[ptr_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      cnt_d          = cnt_q;
      host_cmd_ready = 1'b0;
      host_in_ready  = 1'b0;
      host_out_valid = 1'b0;
      host_done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            host_cmd_ready = 1'b1;
            if (host_cmd_valid) begin
               ptr_d   = host_cmd_addr;
               cnt_d   = host_cmd_len;
               state_d = host_cmd_op ? S_DUMP_REQ : S_LOAD;
            end
         end
         S_LOAD: begin
            host_in_ready = 1'b1;
            if (host_in_valid) begin
               if (cnt_q == 8'd0) begin
                  state_d = S_DONE;
               end else begin
                  ptr_d = ptr_q + 1'b1;
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         S_DUMP_REQ: state_d = S_DUMP_HOLD;
         S_DUMP_HOLD: begin
            host_out_valid = 1'b1;
            if (host_out_ready) begin
               if (cnt_q == 8'd0) begin
                  state_d = S_DONE;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  cnt_d   = cnt_q - 8'd1;
                  state_d = S_DUMP_REQ;
               end
            end
         end
         S_DONE: begin
            host_done = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bram_dout     = dout_q;
   assign host_out_data = rd_q;
   assign busy          = (state_q != S_IDLE);

endmodule
